m68k_dtack_responder: RTL and testbench
=======================================

Name: m68k_dtack_responder

Overview:
- Bus-cycle responder for the 68000 side of the system.
- Consumes the chip-select outputs of the address decoder plus CPU strobes, and terminates every cycle with Dtack_L after a per-region number of wait states.
- For DRAM and graphics, forwards the handshake from the downstream controller instead.
- Asserts BErr_L when a cycle hits no device or no device answers before a watchdog expires.

Parameters:
- ROM_WAIT, 1, wait clocks after strobe detect before Dtack_L for on-chip ROM.
- RAM_WAIT, 1, wait clocks for on-chip RAM.
- IO_WAIT, 4, wait clocks for the IO region.
- CAN_WAIT, 8, wait clocks for the CAN bus controller.
- TIMEOUT, 255, clocks from strobe detect to BErr_L if no acknowledge; must be greater than every *_WAIT.
- CNT_W, 8, width of the wait/watchdog counters; all counts must fit in CNT_W bits.

Ports:
- Clk  in  1  system clock.
- Reset_H  in  1  synchronous reset, active-high.
- AS_L  in  1  CPU address strobe.
- UDS_L  in  1  upper data strobe.
- LDS_L  in  1  lower data strobe.
- OnChipRomSelect_H  in  1  decoder select.
- OnChipRamSelect_H  in  1  decoder select.
- DramSelect_H  in  1  decoder select.
- IOSelect_H  in  1  decoder select.
- CanBusSelect_H  in  1  decoder select.
- GraphicsCS_L  in  1  decoder select, active-low.
- DramDtack_L  in  1  acknowledge from DRAM controller.
- GraphicsDtack_L  in  1  acknowledge from graphics controller.
- Dtack_L  out  1  data acknowledge to CPU.
- BErr_L  out  1  bus error to CPU.
- BusyRegion  out  3  region of the current cycle: 0 none, 1 ROM, 2 RAM, 3 DRAM, 4 IO, 5 CAN, 6 GFX; debug only.

Behaviour:
- Reset (Reset_H high at a Clk edge): state IDLE, Dtack_L=1, BErr_L=1, BusyRegion=0, counters cleared. This applies in any state, including mid-cycle; no pending acknowledge survives reset.
- Inputs are sampled on rising Clk. Strobe detect means AS_L=0 and (UDS_L=0 or LDS_L=0) on the same edge.

States:
- IDLE
  - On strobe detect, latch the region from the selects. Priority if more than one select is active: ROM > RAM > DRAM > IO > CAN > GFX.
  - Clear the watchdog and load the wait counter with the region's *_WAIT.
  - Go to WAIT if a region is selected, otherwise to BERR.
- WAIT
  - Watchdog increments every clock.
  - Fixed-wait regions (ROM/RAM/IO/CAN): the counter decrements each clock. When it reaches 0, go to ACK. A *_WAIT of 0 therefore gives ACK on the clock after detect.
  - DRAM/GFX: go to ACK on the first clock the matching DramDtack_L/GraphicsDtack_L is sampled low.
  - If the watchdog reaches TIMEOUT first, go to BERR. If acknowledge and timeout occur on the same edge, acknowledge wins.
  - If AS_L goes high while in WAIT (aborted cycle), go to IDLE with no Dtack_L or BErr_L.
- ACK
  - Dtack_L=0, registered, so it is asserted from the clock after the transition.
  - Held until AS_L is sampled high, then Dtack_L=1 and go to IDLE.
- BERR
  - BErr_L=0, Dtack_L stays 1.
  - Held until AS_L is sampled high, then BErr_L=1 and go to IDLE.

Output and sampling rules:
- Dtack_L and BErr_L are never low together.
- Both are deasserted on the edge where AS_L is sampled high.
- A new cycle is not recognised until IDLE has been reached, so back-to-back cycles need AS_L high for at least one sampled clock.
- Decoder selects are sampled only at strobe detect; later changes mid-cycle are ignored.
- BusyRegion holds the latched region in WAIT, ACK and BERR, and is 0 in IDLE.

Test Plan:
- Reset check: hold Reset_H for 2 clocks with random inputs -> Dtack_L=1, BErr_L=1, BusyRegion=0.
- ROM read timing: OnChipRomSelect_H=1, assert AS_L/UDS_L at clock n -> Dtack_L low at clock n+2 (ROM_WAIT=1). It stays low until AS_L is released, then is high one clock after release is sampled.
- DRAM handshake: DramSelect_H=1, drive DramDtack_L low 10 clocks after strobe -> Dtack_L low the clock after DramDtack_L is sampled low, and BErr_L stays 1.
- Unmapped address: all selects inactive, strobe asserted -> BErr_L low the clock after detect, Dtack_L stays 1. Separately, GraphicsCS_L=0 with GraphicsDtack_L held high -> BErr_L low once the watchdog reaches TIMEOUT=255.
- Priority and simultaneity: ROM and IO selects both high -> BusyRegion=1 with ROM timing. In the same run, DramDtack_L falls on the same edge the watchdog hits TIMEOUT -> Dtack_L, not BErr_L.
- Reset and abort mid-cycle: pulse Reset_H while in WAIT with IO_WAIT=4 -> state IDLE and no Dtack_L afterwards. Separately, release AS_L during WAIT -> IDLE with no acknowledge, and the next cycle is handled normally.

Source files
------------

// File: rtl/m68k_dtack_responder_if.sv
// 68000 bus-cycle signals that pass between the CPU/decoder side and the DTACK responder.
// The master side drives strobes, selects and downstream acknowledges; the slave terminates cycles.
interface m68k_dtack_responder_if;
    logic       AS_L;
    logic       UDS_L;
    logic       LDS_L;
    logic       OnChipRomSelect_H;
    logic       OnChipRamSelect_H;
    logic       DramSelect_H;
    logic       IOSelect_H;
    logic       CanBusSelect_H;
    logic       GraphicsCS_L;
    logic       DramDtack_L;
    logic       GraphicsDtack_L;
    logic       Dtack_L;
    logic       BErr_L;
    logic [2:0] BusyRegion;

    modport master (
        output AS_L, UDS_L, LDS_L,
        output OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
        output IOSelect_H, CanBusSelect_H, GraphicsCS_L,
        output DramDtack_L, GraphicsDtack_L,
        input  Dtack_L, BErr_L, BusyRegion
    );

    modport slave (
        input  AS_L, UDS_L, LDS_L,
        input  OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
        input  IOSelect_H, CanBusSelect_H, GraphicsCS_L,
        input  DramDtack_L, GraphicsDtack_L,
        output Dtack_L, BErr_L, BusyRegion
    );
endinterface

// File: rtl/m68k_dtack_responder.sv
// Terminates 68000 bus cycles with Dtack_L after per-region wait states, forwards DRAM/graphics
// handshakes, and raises BErr_L for unmapped addresses or when the watchdog expires.
module m68k_dtack_responder #(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 4,
    parameter int CAN_WAIT = 8,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_H,
    m68k_dtack_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR
    } state_t;

    typedef enum logic [2:0] {
        R_NONE = 3'd0,
        R_ROM  = 3'd1,
        R_RAM  = 3'd2,
        R_DRAM = 3'd3,
        R_IO   = 3'd4,
        R_CAN  = 3'd5,
        R_GFX  = 3'd6
    } region_t;

    localparam logic [CNT_W-1:0] LP_ROM_WAIT   = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] LP_RAM_WAIT   = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] LP_IO_WAIT    = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] LP_CAN_WAIT   = CNT_W'(CAN_WAIT);
    // The watchdog holds the number of WAIT clocks already elapsed, so expiry is one short of TIMEOUT.
    localparam logic [CNT_W-1:0] LP_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    region_t          r_region;
    region_t          w_sel_region;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_wdog;
    logic [CNT_W-1:0] w_sel_wait;
    logic             r_dtack_l;
    logic             r_berr_l;
    logic             w_strobe;
    logic             w_ack;
    logic             w_timeout;

    assign w_strobe  = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);
    assign w_timeout = (r_wdog == LP_TIMEOUT_M1);

    // Priority decode of the selects: ROM > RAM > DRAM > IO > CAN > GFX.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_sel_region = R_NONE;
        w_sel_wait   = '0;
        if (bus.OnChipRomSelect_H) begin
            w_sel_region = R_ROM;
            w_sel_wait   = LP_ROM_WAIT;
        end else if (bus.OnChipRamSelect_H) begin
            w_sel_region = R_RAM;
            w_sel_wait   = LP_RAM_WAIT;
        end else if (bus.DramSelect_H) begin
            w_sel_region = R_DRAM;
        end else if (bus.IOSelect_H) begin
            w_sel_region = R_IO;
            w_sel_wait   = LP_IO_WAIT;
        end else if (bus.CanBusSelect_H) begin
            w_sel_region = R_CAN;
            w_sel_wait   = LP_CAN_WAIT;
        end else if (!bus.GraphicsCS_L) begin
            w_sel_region = R_GFX;
        end
    end

    always_comb begin
        w_ack = 1'b0;
        case (r_region)
            R_ROM, R_RAM, R_IO, R_CAN: w_ack = (r_wait_cnt == '0);
            R_DRAM:                    w_ack = !bus.DramDtack_L;
            R_GFX:                     w_ack = !bus.GraphicsDtack_L;
            default:                   w_ack = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    w_next_state = (w_sel_region == R_NONE) ? S_BERR : S_WAIT;
                end
            end
            S_WAIT: begin
                // Abort beats acknowledge, and acknowledge beats the watchdog.
                if (bus.AS_L) begin
                    w_next_state = S_IDLE;
                end else if (w_ack) begin
                    w_next_state = S_ACK;
                end else if (w_timeout) begin
                    w_next_state = S_BERR;
                end
            end
            S_ACK, S_BERR: begin
                if (bus.AS_L) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: reset is synchronous; counters and the latched region are cleared with the state so nothing survives it.
        if (Reset_H) begin
            r_state    <= S_IDLE;
            r_region   <= R_NONE;
            r_wait_cnt <= '0;
            r_wdog     <= '0;
            r_dtack_l  <= 1'b1;
            r_berr_l   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            r_state   <= w_next_state;
            r_dtack_l <= (w_next_state != S_ACK);
            r_berr_l  <= (w_next_state != S_BERR);

            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_region   <= w_sel_region;
                        r_wait_cnt <= w_sel_wait;
                        r_wdog     <= '0;
                    end
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + LP_ONE;
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - LP_ONE;
                    end
                end
                default: ;
            endcase

            if (w_next_state == S_IDLE) begin
                r_region <= R_NONE;
            end
        end
    end

    assign bus.Dtack_L    = r_dtack_l;
    assign bus.BErr_L     = r_berr_l;
    assign bus.BusyRegion = r_region;

endmodule

// File: tb/tb_m68k_dtack_responder.sv
// Randomized scoreboard bench for m68k_dtack_responder: a cycle-level model predicts each
// termination (kind, edge, region, release edge); a negedge monitor compares what the DUT presents.
module tb_m68k_dtack_responder;

    localparam int ROM_WAIT = 1;
    localparam int RAM_WAIT = 1;
    localparam int IO_WAIT  = 4;
    localparam int CAN_WAIT = 8;
    localparam int TIMEOUT  = 255;
    localparam int NEVER    = 100000;

    typedef struct {
        bit is_berr;
        int region;
        int t_assert;
        int t_release;
    } resp_t;

    logic   Clk = 1'b0;
    logic   Reset_H;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    bit     mon_en = 1'b0;
    bit     active = 1'b0;
    resp_t  sb_q[$];
    resp_t  cur;

    m68k_dtack_responder_if bus();

    m68k_dtack_responder #(
        .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT),
        .CAN_WAIT(CAN_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(8)
    ) dut (
        .Clk    (Clk),
        .Reset_H(Reset_H),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Selects packed as {rom, ram, dram, io, can, gfx}; the leftmost set bit wins.
    function automatic int model_region(input logic [5:0] sel);
        for (int i = 5; i >= 0; i--) begin
            if (sel[i]) return 6 - i;
        end
        return 0;
    endfunction

    function automatic int model_wait(input int region);
        case (region)
            1: return ROM_WAIT;
            2: return RAM_WAIT;
            4: return IO_WAIT;
            5: return CAN_WAIT;
            default: return 0;
        endcase
    endfunction

    task automatic drive_selects(input logic [5:0] sel);
        bus.OnChipRomSelect_H = sel[5];
        bus.OnChipRamSelect_H = sel[4];
        bus.DramSelect_H      = sel[3];
        bus.IOSelect_H        = sel[2];
        bus.CanBusSelect_H    = sel[1];
        bus.GraphicsCS_L      = !sel[0];
    endtask

    task automatic bus_idle();
        bus.AS_L            = 1'b1;
        bus.UDS_L           = 1'b1;
        bus.LDS_L           = 1'b1;
        bus.DramDtack_L     = 1'b1;
        bus.GraphicsDtack_L = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        bus_idle();
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // One CPU cycle: strobe sampled at edge d, downstream ack sampled low from edge d+k,
    // AS_L released so it is sampled high at edge d+h.
    task automatic run_cycle(input logic [5:0] sel, input int k, input int hold_extra,
                             input bit do_abort, input logic [1:0] ds);
        int d, r, h, region;
        bit berr, aborted;
        region  = model_region(sel);
        berr    = 1'b0;
        aborted = 1'b0;
        if (region == 0) begin
            r    = 0;
            berr = 1'b1;
        end else if (region == 3 || region == 6) begin
            if (k <= TIMEOUT) r = k;
            else begin
                r    = TIMEOUT;
                berr = 1'b1;
            end
        end else begin
            r = model_wait(region) + 1;
        end
        if (do_abort && r >= 2) begin
            h       = $urandom_range(1, r - 1);
            aborted = 1'b1;
        end else begin
            h = r + 1 + hold_extra;
        end

        @(posedge Clk);
        #1;
        d = cyc + 1;
        if (!aborted) sb_q.push_back('{berr, region, d + r, d + h});
        for (int j = 0; j <= h; j++) begin
            if (j > 0) begin
                @(posedge Clk);
                #1;
            end
            if (j == h) begin
                bus_idle();
            end else begin
                bus.AS_L = 1'b0;
                {bus.UDS_L, bus.LDS_L} = ds;
                drive_selects((j == 0) ? sel : 6'($urandom));
                bus.DramDtack_L     = (region == 3) ? !(j >= k) : 1'($urandom);
                bus.GraphicsDtack_L = (region == 6) ? !(j >= k) : 1'($urandom);
            end
        end
    endtask

    function automatic logic [1:0] rand_ds();
        case ($urandom_range(0, 2))
            0:       return 2'b01;
            1:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            if (!bus.Dtack_L || !bus.BErr_L) begin
                check("dtack_berr_exclusive", int'(!bus.Dtack_L && !bus.BErr_L), 0);
                if (!active) begin
                    if (sb_q.size() == 0) begin
                        check("response_expected", sb_q.size(), 1);
                    end else begin
                        cur    = sb_q.pop_front();
                        active = 1'b1;
                        check("resp_is_dtack", int'(!bus.Dtack_L), cur.is_berr ? 0 : 1);
                        check("resp_is_berr", int'(!bus.BErr_L), cur.is_berr ? 1 : 0);
                        check("resp_cycle", cyc, cur.t_assert);
                        check("busy_region", int'(bus.BusyRegion), cur.region);
                    end
                end
            end else begin
                if (active) begin
                    active = 1'b0;
                    check("release_cycle", cyc, cur.t_release);
                    check("idle_busy_region", int'(bus.BusyRegion), 0);
                end else if (sb_q.size() > 0 && cyc > sb_q[0].t_assert) begin
                    check("resp_missing_due_cycle", cyc, sb_q[0].t_assert);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "time budget exceeded");
    end

    initial begin
        logic [5:0] sel;
        Reset_H = 1'b1;
        bus.AS_L  = 1'($urandom);
        bus.UDS_L = 1'($urandom);
        bus.LDS_L = 1'($urandom);
        drive_selects(6'($urandom));
        bus.DramDtack_L     = 1'($urandom);
        bus.GraphicsDtack_L = 1'($urandom);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_dtack", int'(bus.Dtack_L), 1);
        check("reset_berr", int'(bus.BErr_L), 1);
        check("reset_busy", int'(bus.BusyRegion), 0);
        bus_idle();
        Reset_H = 1'b0;
        idle_cycles(2);
        mon_en = 1'b1;

        run_cycle(6'b100000, NEVER, 2, 1'b0, 2'b01);   // ROM read timing
        run_cycle(6'b001000, 10, 1, 1'b0, 2'b00);      // DRAM handshake
        run_cycle(6'b000000, NEVER, 1, 1'b0, 2'b10);   // unmapped
        run_cycle(6'b000001, NEVER, 0, 1'b0, 2'b00);   // graphics never answers
        run_cycle(6'b100100, NEVER, 1, 1'b0, 2'b01);   // ROM beats IO
        run_cycle(6'b001000, TIMEOUT, 1, 1'b0, 2'b00); // ack on the watchdog edge
        run_cycle(6'b010000, NEVER, 0, 1'b0, 2'b10);   // RAM
        run_cycle(6'b000010, NEVER, 3, 1'b0, 2'b00);   // CAN

        // Reset pulse while an IO cycle is waiting: no acknowledge may follow.
        sel = 6'b000100;
        @(posedge Clk);
        #1;
        bus.AS_L = 1'b0;
        {bus.UDS_L, bus.LDS_L} = 2'b00;
        drive_selects(sel);
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        Reset_H = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("midcycle_reset_dtack", int'(bus.Dtack_L), 1);
        check("midcycle_reset_busy", int'(bus.BusyRegion), 0);
        Reset_H = 1'b0;
        bus_idle();
        idle_cycles(12);

        // Aborted IO cycle, then a normal one.
        run_cycle(6'b000100, NEVER, 0, 1'b1, 2'b00);
        run_cycle(6'b000100, NEVER, 1, 1'b0, 2'b00);

        // AS_L without a data strobe is never detected.
        @(posedge Clk);
        #1;
        bus.AS_L = 1'b0;
        drive_selects(6'b100000);
        idle_cycles(0);
        bus.AS_L = 1'b0;
        repeat (5) begin
            @(posedge Clk);
            #1;
        end
        idle_cycles(2);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) sel = 6'b0;
            else sel = 6'(1 << $urandom_range(0, 5)) | (($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0);
            run_cycle(sel, $urandom_range(1, 20), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0), rand_ds());
        end

        idle_cycles(10);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
